// File: rtl/pipe_pkg.sv
// Shared writeback types: queue entry layout and exception cause codes.
// Entry field widths match the default DATA_W/ADDR_W of pipe_wb_q.
package pipe_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   typedef struct packed {
      logic [WB_DATA_W-1:0] result;
      logic [WB_ADDR_W-1:0] rdc;
      logic                 we;
      logic                 ex_flag;
      logic [4:0]           ex_code;
      logic [WB_DATA_W-1:0] pc;
   } wb_entry_t;

endpackage

// File: rtl/pipe_wb_q_queue.sv
// Writeback queue storage: circular buffer with flush and
// per-entry read-out ordered oldest (index 0) to youngest.
module wb_queue
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  wb_entry_t                push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output wb_entry_t                age_ent [DEPTH],
   output logic [DEPTH-1:0]         age_vld
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Payload storage carries no reset; validity lives in cnt.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         age_ent[k] = mem[rd_ptr + PTR_W'(k)];
         age_vld[k] = (CNT_W'(k) < cnt);
      end
   end

endmodule

// File: rtl/pipe_wb_q.sv
// Writeback queue stage: head retire, exception flush, bypass lookup.
// Define PIPE_WB_Q_BYPASS_EN to build the bypass compare network.
module pipe_wb_q
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_wb_validto,
   output logic                   wb_allowin,
   input  logic [DATA_W-1:0]      wb_result_in,
   input  logic [ADDR_W-1:0]      rdc_mem_in,
   input  logic                   rf_we_in,
   input  logic                   ex_wb_in,
   input  logic [4:0]             ex_code_in,
   input  logic [DATA_W-1:0]      pc_in,
   input  logic                   rf_wr_ready,
   output logic                   rf_we,
   output logic [ADDR_W-1:0]      rdc_wb,
   output logic [DATA_W-1:0]      wb_result,
   output logic                   ex,
   output logic [4:0]             ex_code,
   output logic [DATA_W-1:0]      ex_pc,
   input  logic [ADDR_W-1:0]      byp_rdc,
   output logic                   byp_hit,
   output logic [DATA_W-1:0]      byp_data,
   output logic [$clog2(DEPTH):0] wb_count
);

   wb_entry_t        in_ent;
   wb_entry_t        head;
   wb_entry_t        age_ent [DEPTH];
   logic [DEPTH-1:0] age_vld;
   logic             head_valid;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   always_comb begin
      in_ent         = '0;
      in_ent.result  = wb_result_in;
      in_ent.rdc     = rdc_mem_in;
      in_ent.we      = rf_we_in;
      in_ent.ex_flag = ex_wb_in;
      in_ent.ex_code = ex_code_in;
      in_ent.pc      = pc_in;
   end

   wb_queue #(
      .DEPTH     (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_ent),
      .pop       (pop),
      .flush     (ex),
      .full      (full),
      .empty     (empty),
      .count     (wb_count),
      .age_ent   (age_ent),
      .age_vld   (age_vld)
   );

   assign head       = age_ent[0];
   assign head_valid = ~empty;
   assign wb_allowin = ~full;

   assign rf_we     = head_valid & head.we & ~head.ex_flag
                    & (head.rdc != '0);
   assign rdc_wb    = head.rdc;
   assign wb_result = head.result;

   // An exception head retires immediately and flushes everything behind it.
   assign ex      = head_valid & head.ex_flag;
   assign ex_code = head.ex_code;
   assign ex_pc   = head.pc;

   assign pop  = (rf_we & rf_wr_ready) | (head_valid & ~rf_we);
   assign push = mem_wb_validto & wb_allowin & ~ex;

`ifdef PIPE_WB_Q_BYPASS_EN
   // Later (younger) matches override earlier ones.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_vld[k] && age_ent[k].we && !age_ent[k].ex_flag
             && age_ent[k].rdc == byp_rdc && byp_rdc != '0) begin
            byp_hit  = 1'b1;
            byp_data = age_ent[k].result;
         end
      end
   end
`else
   logic unused_ok;

   assign byp_hit  = 1'b0;
   assign byp_data = '0;

   always_comb begin
      unused_ok = ^{byp_rdc, age_vld};
      for (int k = 1; k < DEPTH; k++) begin
         unused_ok = unused_ok ^ (^age_ent[k]);
      end
   end
`endif

endmodule

// File: doc/pipe_wb_q.md
PIPE_WB_Q -- requirements
Module: pipe_wb_q

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result/PC data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-file index width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning writeback queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port mem_wb_validto  input  1  MEM stage offers an instruction.
REQ-007 SHALL have port wb_allowin  output  1  queue can accept this cycle.
REQ-008 SHALL have ports wb_result_in (DATA_W), rdc_mem_in (ADDR_W), rf_we_in (1), ex_wb_in (1), ex_code_in (5), pc_in (DATA_W), all inputs, the offered instruction's payload.
REQ-009 SHALL have port rf_wr_ready  input  1  shared register-file write port is free this cycle.
REQ-010 SHALL have ports rf_we (1), rdc_wb (ADDR_W), wb_result (DATA_W), all outputs, the register-file write request.
REQ-011 SHALL have ports ex (1), ex_code (5), ex_pc (DATA_W), all outputs, the exception retire pulse and its cause and PC.
REQ-012 SHALL have ports byp_rdc  input  ADDR_W, byp_hit  output  1, byp_data  output  DATA_W, the bypass lookup.
REQ-013 SHALL have port wb_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL enqueue at posedge when mem_wb_validto && wb_allowin && !ex; wb_allowin = (wb_count < DEPTH), with no same-cycle fall-through.
REQ-015 SHALL present the head entry to rf_we/rdc_wb/wb_result no earlier than the cycle after enqueue (minimum latency 1 cycle).
REQ-016 SHALL drive rf_we = head_valid & we & !ex_flag & (rdc != 0).
REQ-017 SHALL retire the head when (rf_we && rf_wr_ready) or (head_valid && !rf_we); a write entry waits while rf_wr_ready=0.
REQ-018 SHALL drive ex=1 combinationally for exactly the cycle a head with ex_flag=1 retires, with ex_code/ex_pc taken from that entry.
REQ-019 SHALL, in a cycle with ex=1, drop any enqueue and empty the queue (wb_count=0) at the next posedge.
REQ-020 SHALL keep wb_count correct under simultaneous enqueue and retire: count unchanged, pointers wrap modulo DEPTH.
REQ-021 SHALL, when full and retiring in the same cycle, still hold wb_allowin=0 that cycle.
REQ-022 SHALL drive byp_hit=1 iff some valid entry has we=1, ex_flag=0, rdc==byp_rdc and byp_rdc!=0; byp_data SHALL be the youngest such entry's result.
REQ-023 SHALL drive byp_data to 0 when byp_hit=0.

Reset
REQ-024 SHALL, with rst=1 at posedge, clear pointers and count; outputs then read wb_allowin=1, wb_count=0, rf_we=0, ex=0, byp_hit=0, byp_data=0.
REQ-025 SHALL let rst override any in-flight enqueue, retire or ex in that cycle; entry storage SHALL NOT be reset.

Configuration
REQ-026 SHALL, with macro PIPE_WB_Q_BYPASS_EN defined, implement REQ-022/REQ-023 lookup.
REQ-027 SHALL, with PIPE_WB_Q_BYPASS_EN undefined, tie byp_hit=0 and byp_data=0, contain no compare logic, and leave byp_rdc unused.

Structure
REQ-028 SHALL take typedef wb_entry_t (result, rdc, we, ex_flag, ex_code, pc) and exception-code constants from the shared package pipe_pkg.
REQ-029 SHALL place storage and pointers in one sub-module wb_queue (push, pop, flush, full, empty, count, per-entry read-out); head logic, exception and bypass stay in pipe_wb_q.

Verification
REQ-030 SHALL cover streaming: 6 back-to-back writes rdc=1..6, rf_wr_ready=1 -> rf_we one per cycle from cycle 1, rdc_wb 1..6 in order, wb_count <=1.
REQ-031 SHALL cover backpressure: rf_wr_ready=0, 5 offers -> 4 accepted, wb_allowin=0 at count 4, 5th held; release -> 4 writes in order, then 5th accepted.
REQ-032 SHALL cover exception flush: queue {w r3, ex code 0x0C pc 0xBFC00100, w r4} -> r3 written, ex=1 with code 0x0C/pc 0xBFC00100 for one cycle, r4 never written, wb_count=0 next cycle, same-cycle offer dropped.
REQ-033 SHALL cover bypass: entries r7=0x11, r7=0x22, r0=0x33; byp_rdc=7 -> hit, 0x22; byp_rdc=0 -> no hit; macro off -> byp_hit=0 always.
REQ-034 SHALL cover reset mid-operation: rst with 3 entries and rf_wr_ready=0 -> next cycle wb_count=0, rf_we=0, wb_allowin=1, no write issued.
REQ-035 SHALL cover wrap and r0: 20 entries interleaving rdc=0 and rdc=9 with random rf_wr_ready -> rdc 0 entries retire without rf_we, all r9 writes in order, no loss or duplication.
